bram_fifo_ctrl: RTL



---
 rtl/bram_fifo_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - 512x16 streaming FIFO controller driving one BlockRAM_1KB tile
// A 2-entry output buffer absorbs the one-cycle RAM read latency for 1 word/cycle throughput.
module bram_fifo_ctrl #(
  parameter int WE_BIT     = 20,
  parameter int WR_SEL_LSB = 16,
  parameter int RD_SEL_LSB = 24,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [15:0]           m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2-2:0] bram_rd_addr,
  output logic [DEPTH_LOG2-2:0] bram_wr_addr,
  output logic [31:0]           bram_wr_data,
  input  logic [31:0]           bram_rd_data,
  output logic [5:0]            bram_cfg
);

  localparam int PW = DEPTH_LOG2;
  localparam logic [PW:0] RAM_FULL = {1'b1, {PW{1'b0}}};

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   ram_cnt;
  logic          inflight;
  logic [1:0]    ob_cnt;
  logic [15:0]   ob0;
  logic [15:0]   ob1;

  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    pending;
  logic [1:0]    slot;
  logic          unused_rd_hi;

  assign s_ready  = !rst && (ram_cnt != RAM_FULL);
  assign m_valid  = !rst && (ob_cnt != 2'd0);
  assign push     = s_valid && s_ready;
  assign pop      = m_valid && m_ready;
  assign m_data   = ob0;
  assign bram_cfg = 6'b00_1_0_1_0;

  // Entries already committed to the output stage once this cycle's pop leaves.
  assign pending = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue   = !rst && (ram_cnt != '0) && (pending < 3'd2);

  assign count = ram_cnt + {{PW{1'b0}}, inflight} + {{(PW-1){1'b0}}, ob_cnt};

  assign bram_rd_addr = rd_ptr[PW-2:0];
  assign bram_wr_addr = wr_ptr[PW-2:0];
  assign unused_rd_hi = ^bram_rd_data[31:16];

  // Pointer MSB selects the 16-bit half of each 32-bit tile word.
  always_comb begin
    bram_wr_data             = '0;
    bram_wr_data[15:0]       = s_data;
    bram_wr_data[WR_SEL_LSB] = wr_ptr[PW-1];
    bram_wr_data[WE_BIT]     = push;
    bram_wr_data[RD_SEL_LSB] = rd_ptr[PW-1];
  end

  assign slot = ob_cnt - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
      ob0      <= '0;
      ob1      <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      inflight <= issue;

      case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase

      ob_cnt <= ob_cnt + {1'b0, inflight} - {1'b0, pop};
      if (pop) ob0 <= ob1;
      // Arrival lands behind whatever survives this cycle's pop.
      if (inflight) begin
        if (slot == 2'd0) ob0 <= bram_rd_data[15:0];
        else              ob1 <= bram_rd_data[15:0];
      end
    end
  end

endmodule
